// File: rtl/adder_resp_checker.sv
// adder_resp_checker: scores a stream of full-adder responses against the
// golden x^y^cin / majority(x,y,cin) and reports vector/error counts per run.
// Optional build macro ADDER_CHK_FIRSTFAIL_EN adds fail_vld/fail_vec, which
// record the stimulus of the first mismatching response of a run.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | after reset, waiting for start; vld ignored
// S_RUN  | accepting responses; start ignored
// S_DONE | NVEC responses accepted, results held; start re-arms a run
module adder_resp_checker #(
    parameter int NVEC  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic [2:0]       vec,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef ADDER_CHK_FIRSTFAIL_EN
    ,
    output logic             fail_vld,
    output logic [2:0]       fail_vec
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NVEC - 1);

    state_t state;
    state_t state_nxt;
    logic   clr;
    logic   accept;
    logic   gold_sum;
    logic   gold_cout;
    logic   mismatch;

    assign gold_sum  = vec[0] ^ vec[1] ^ vec[2];
    assign gold_cout = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
    // Both bits wrong still collapses into a single mismatch.
    assign mismatch  = (sum != gold_sum) || (cout != gold_cout);
    assign pass      = done && (err_cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the run-control strobes derived from state.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                accept = vld;
                if (vld && (vec_cnt == LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Vector and error counters; error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (mismatch && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef ADDER_CHK_FIRSTFAIL_EN
    // First-failure capture; later mismatches in the same run are ignored.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail_vld <= 1'b0;
            fail_vec <= '0;
        end else if (accept && mismatch && !fail_vld) begin
            fail_vld <= 1'b1;
            fail_vec <= vec;
        end
    end
`endif

endmodule

// File: tb/tb_adder_resp_checker.sv
// Bench for adder_resp_checker: two instances (default and CNT_W=2/NVEC=3)
// are stepped together; a reference model predicts each cycle's outputs,
// pushes them to a queue before the edge and pops/compares them after it.
module tb_adder_resp_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       st0 = 1'b0, v0 = 1'b0, s0 = 1'b0, c0 = 1'b0;
    logic [2:0] vec0 = '0;
    logic       st1 = 1'b0, v1 = 1'b0, s1 = 1'b0, c1 = 1'b0;
    logic [2:0] vec1 = '0;

    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] vc0, ec0;
    logic [1:0]  vc1, ec1;
`ifdef ADDER_CHK_FIRSTFAIL_EN
    logic        fv0, fv1;
    logic [2:0]  fvec0, fvec1;
`endif

    adder_resp_checker u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .vld(v0), .vec(vec0), .sum(s0), .cout(c0),
        .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0), .err_cnt(ec0)
`ifdef ADDER_CHK_FIRSTFAIL_EN
        , .fail_vld(fv0), .fail_vec(fvec0)
`endif
    );

    adder_resp_checker #(.NVEC(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .vld(v1), .vec(vec1), .sum(s1), .cout(c1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vc1), .err_cnt(ec1)
`ifdef ADDER_CHK_FIRSTFAIL_EN
        , .fail_vld(fv1), .fail_vec(fvec1)
`endif
    );

    // st: 0 idle, 1 run, 2 done
    typedef struct {
        int st;
        int vc;
        int ec;
        bit fv;
        int fvec;
    } mdl_t;

    mdl_t m0 = '{0, 0, 0, 0, 0};
    mdl_t m1 = '{0, 0, 0, 0, 0};
    mdl_t q0[$];
    mdl_t q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] gold(input logic [2:0] v);
        int tot;
        tot = int'(v[0]) + int'(v[1]) + int'(v[2]);
        return tot[1:0];
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input int nvec, input int emax,
                                        input bit r, input bit st, input bit v,
                                        input logic [2:0] vv, input bit s, input bit co);
        mdl_t       n;
        logic [1:0] g;
        bit         bad;
        n = c;
        if (r) begin
            n = '{0, 0, 0, 0, 0};
        end else if (c.st == 1) begin
            if (v) begin
                g   = gold(vv);
                bad = (s != g[0]) || (co != g[1]);
                n.vc++;
                if (bad && n.ec < emax) n.ec++;
                if (bad && !n.fv) begin
                    n.fv   = 1'b1;
                    n.fvec = int'(vv);
                end
                if (n.vc == nvec) n.st = 2;
            end
        end else if (st) begin
            n = '{1, 0, 0, 0, 0};
        end
        return n;
    endfunction

    task automatic tick();
        mdl_t e0, e1;
        e0 = model_next(m0, 8, 65535, rst, st0, v0, vec0, s0, c0);
        e1 = model_next(m1, 3, 3, rst, st1, v1, vec1, s1, c1);
        q0.push_back(e0);
        q1.push_back(e1);
        m0 = e0;
        m1 = e1;
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check_val("d0.busy", 32'(busy0), 32'(e0.st == 1));
        check_val("d0.done", 32'(done0), 32'(e0.st == 2));
        check_val("d0.pass", 32'(pass0), 32'(e0.st == 2 && e0.ec == 0));
        check_val("d0.vec_cnt", 32'(vc0), e0.vc);
        check_val("d0.err_cnt", 32'(ec0), e0.ec);
        check_val("d1.busy", 32'(busy1), 32'(e1.st == 1));
        check_val("d1.done", 32'(done1), 32'(e1.st == 2));
        check_val("d1.pass", 32'(pass1), 32'(e1.st == 2 && e1.ec == 0));
        check_val("d1.vec_cnt", 32'(vc1), e1.vc);
        check_val("d1.err_cnt", 32'(ec1), e1.ec);
`ifdef ADDER_CHK_FIRSTFAIL_EN
        check_val("d0.fail_vld", 32'(fv0), 32'(e0.fv));
        check_val("d0.fail_vec", 32'(fvec0), e0.fvec);
        check_val("d1.fail_vld", 32'(fv1), 32'(e1.fv));
        check_val("d1.fail_vec", 32'(fvec1), e1.fvec);
`endif
    endtask

    task automatic resp0(input logic [2:0] v, input bit flip_s, input bit flip_c);
        logic [1:0] g;
        g    = gold(v);
        vec0 = v;
        v0   = 1'b1;
        s0   = g[0] ^ flip_s;
        c0   = g[1] ^ flip_c;
        tick();
    endtask

    task automatic resp1(input logic [2:0] v, input bit flip_s, input bit flip_c);
        logic [1:0] g;
        g    = gold(v);
        vec1 = v;
        v1   = 1'b1;
        s1   = g[0] ^ flip_s;
        c1   = g[1] ^ flip_c;
        tick();
    endtask

    task automatic start0();
        st0 = 1'b1;
        tick();
        st0 = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        check_val("rst.vec_cnt", 32'(vc0), 0);
        check_val("rst.busy", 32'(busy0), 0);
        rst = 1'b0;

        // eight correct responses back-to-back
        start0();
        for (int i = 0; i < 8; i++) resp0(3'(i), 1'b0, 1'b0);
        v0 = 1'b0;
        check_val("t1.done", 32'(done0), 1);
        check_val("t1.vec_cnt", 32'(vc0), 8);
        check_val("t1.pass", 32'(pass0), 1);
        tick();

        // vec=3 returns sum wrong, vec=5 returns both wrong
        start0();
        for (int i = 0; i < 8; i++) resp0(3'(i), (i == 3) || (i == 5), i == 5);
        v0 = 1'b0;
        check_val("t2.err_cnt", 32'(ec0), 2);
        check_val("t2.pass", 32'(pass0), 0);
`ifdef ADDER_CHK_FIRSTFAIL_EN
        check_val("t2.fail_vec", 32'(fvec0), 3);
        check_val("t2.fail_vld", 32'(fv0), 1);
`endif

        // wrong vld pulses in DONE, start pulses during RUN
        resp0(3'd1, 1'b1, 1'b1);
        resp0(3'd2, 1'b1, 1'b0);
        v0 = 1'b0;
        check_val("t3.hold_err", 32'(ec0), 2);
        start0();
        for (int i = 0; i < 8; i++) begin
            st0 = (i % 3 == 1);
            resp0(3'(7 - i), i == 6, 1'b0);
        end
        st0 = 1'b0;
        v0  = 1'b0;
        check_val("t3.vec_cnt", 32'(vc0), 8);
        check_val("t3.err_cnt", 32'(ec0), 1);
        tick();

        // reset mid-run, vld in IDLE, fresh run
        start0();
        for (int i = 0; i < 4; i++) resp0(3'(i), i == 2, 1'b0);
        v0  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t4.vec_cnt", 32'(vc0), 0);
        check_val("t4.busy", 32'(busy0), 0);
        resp0(3'd6, 1'b1, 1'b0);
        resp0(3'd7, 1'b0, 1'b0);
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("t4.no_done", 32'(done0), 0);
        start0();
        for (int i = 0; i < 8; i++) resp0(3'(i), 1'b0, 1'b0);
        v0 = 1'b0;
        check_val("t4.pass", 32'(pass0), 1);

        // narrow instance: all wrong, then restart from DONE
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        for (int i = 0; i < 3; i++) resp1(3'(i + 2), 1'b1, i == 1);
        v1 = 1'b0;
        check_val("t5.err_cnt", 32'(ec1), 3);
        check_val("t5.done", 32'(done1), 1);
        check_val("t5.pass", 32'(pass1), 0);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        check_val("t5.clr_vec", 32'(vc1), 0);
        check_val("t5.clr_err", 32'(ec1), 0);
        for (int i = 0; i < 3; i++) resp1(3'(i), 1'b0, 1'b0);
        v1 = 1'b0;
        check_val("t5.pass2", 32'(pass1), 1);

        // random runs with occasional faults and bubbles
        for (int r = 0; r < 4; r++) begin
            start0();
            while (m0.st == 1) begin
                if ($urandom_range(0, 4) == 0) begin
                    v0 = 1'b0;
                    tick();
                end else begin
                    resp0(3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 4) == 0);
                end
            end
            v0 = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_resp_checker.md
ADDER_RESP_CHECKER -- requirements
Module: adder_resp_checker

Interface
REQ-001 SHALL have parameter NVEC, default 8: number of response vectors checked per run, 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16: width of the vector and error counters.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a run; sampled in IDLE and DONE only.
REQ-006 SHALL have port vld, input, 1: vec/sum/cout hold one valid response this cycle.
REQ-007 SHALL have port vec, input, 3: applied stimulus; x=vec[0], y=vec[1], cin=vec[2].
REQ-008 SHALL have port sum, input, 1: DUT sum output for vec.
REQ-009 SHALL have port cout, input, 1: DUT carry output for vec.
REQ-010 SHALL have port busy, output, 1: high in RUN.
REQ-011 SHALL have port done, output, 1: high in DONE.
REQ-012 SHALL have port pass, output, 1: done and zero errors.
REQ-013 SHALL have port vec_cnt, output, CNT_W: responses accepted in the current run.
REQ-014 SHALL have port err_cnt, output, CNT_W: mismatching responses in the current run.
REQ-015 SHALL have ports fail_vld (1) and fail_vec (3), outputs, present only with ADDER_CHK_FIRSTFAIL_EN.

Function
REQ-016 SHALL compute golden sum = x^y^cin and golden carry = majority(x,y,cin).
REQ-017 SHALL declare a mismatch when vld is high in RUN and sum or cout differs from golden; a response with both bits wrong counts as one error.
REQ-018 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of the NVEC-th response; DONE->RUN on start.
REQ-019 SHALL clear vec_cnt, err_cnt, fail_vld on every IDLE->RUN or DONE->RUN transition, in the same edge.
REQ-020 SHALL ignore vld in IDLE and DONE, and ignore start in RUN.
REQ-021 SHALL update vec_cnt/err_cnt one cycle after the sampling edge of vld (registered, latency 1); done rises at the same edge as vec_cnt reaches NVEC.
REQ-022 SHALL saturate err_cnt at 2^CNT_W-1; vec_cnt never exceeds NVEC.
REQ-023 SHALL accept back-to-back vld every cycle with no bubbles.
REQ-024 SHALL drive pass = 0 whenever done = 0.
REQ-025 SHALL hold vec_cnt, err_cnt, pass stable throughout DONE.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, fail_vld=0, fail_vec=0; rst dominates start and vld.
REQ-027 SHALL abandon a run on rst asserted mid-RUN, with no done pulse afterwards.

Configuration
REQ-028 SHALL, with ADDER_CHK_FIRSTFAIL_EN defined, capture vec of the first mismatch of a run into fail_vec and set fail_vld, both held until next run start or reset; later mismatches do not overwrite.
REQ-029 SHALL, without ADDER_CHK_FIRSTFAIL_EN, omit fail_vld/fail_vec ports and logic; all other behaviour identical.

Verification
REQ-030 Reset then start, 8 correct responses vec=0..7 back-to-back -> done=1 one cycle after 8th vld, vec_cnt=8, err_cnt=0, pass=1.
REQ-031 Run with vec=3 returning sum=1,cout=1 (golden 0,1) and vec=5 returning sum=1,cout=0 -> err_cnt=2, pass=0, fail_vec=3 and fail_vld=1 when macro defined.
REQ-032 vld pulses in IDLE and in DONE, start pulses mid-RUN -> vec_cnt/err_cnt unchanged by them; run completes after exactly 8 accepted responses.
REQ-033 rst asserted after 4 responses in RUN -> next edge all outputs zero, state IDLE; subsequent start runs a fresh 8-vector check to pass=1.
REQ-034 CNT_W=2, NVEC=3, all responses wrong -> err_cnt saturates at 3, done after 3rd, pass=0; restart from DONE clears counters to 0.
